encode_control_signal: RTL and testbench



---
 rtl/encode_control_signal.sv | 125 ++++++++++++
 tb/tb_encode_control_signal.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/encode_control_signal.sv
// Sequential encoder for the 4-bit enable/lock control word, with a settle hold-off after each change.
// Optional rejected-request counter enabled by defining ENCODE_CTRL_ERR_CNT_EN.
module encode_control_signal #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_cmd,
  output logic       req_ready,
  output logic [3:0] control_signal,
  output logic       ack,
  output logic       err,
  output logic       locked,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_e;

  localparam logic [3:0] WORD_EN     = 4'b0001;
  localparam logic [3:0] WORD_DIS    = 4'b0010;
  localparam logic [3:0] WORD_LOCK   = 4'b0011;
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] word_q, word_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic [3:0] target;
  logic       accept;

  assign req_ready      = (state_q != SETTLE);
  assign locked         = (state_q == LOCKED);
  assign control_signal = word_q;
  assign ack            = ack_q;
  assign err            = err_q;
  assign accept         = req_valid && req_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    target = word_q;
    unique case (req_cmd)
      2'b01:   target = WORD_EN;
      2'b10:   target = WORD_DIS;
      2'b11:   target = WORD_LOCK;
      default: target = word_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (target == word_q) begin
            ack_d = 1'b1;
          end else begin
            word_d  = target;
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        // Counter holds the number of SETTLE cycles still to run, including this one.
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          ack_d   = 1'b1;
          state_d = (word_q == WORD_LOCK) ? LOCKED : IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LOCKED: begin
        if (accept) begin
          if (req_cmd == 2'b00) ack_d = 1'b1;
          else                  err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= WORD_DIS;
      cnt_q   <= 8'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef ENCODE_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count advances together with the err pulse and saturates at 8'hFF.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_encode_control_signal.sv
// Scoreboard bench for encode_control_signal: expected ack/err pulses are queued when a
// request is driven and compared cycle-by-cycle by a negedge monitor.
module tb_encode_control_signal;

  localparam int S = 4;
`ifdef ENCODE_CTRL_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [3:0] W_EN   = 4'b0001;
  localparam logic [3:0] W_DIS  = 4'b0010;
  localparam logic [3:0] W_LOCK = 4'b0011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'b00;
  logic       req_ready;
  logic [3:0] control_signal;
  logic       ack, err, locked;
  logic [7:0] err_count;

  encode_control_signal #(.SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_cmd        (req_cmd),
    .req_ready      (req_ready),
    .control_signal (control_signal),
    .ack            (ack),
    .err            (err),
    .locked         (locked),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       ack;
    logic       err;
    logic [3:0] word;
    logic       lock;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rej    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every cycle out of reset, either the head expectation is due or no pulse may appear.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_ack",    32'(ack),            32'(e.ack));
        check("pulse_err",    32'(err),            32'(e.err));
        check("pulse_word",   32'(control_signal), 32'(e.word));
        check("pulse_locked", 32'(locked),         32'(e.lock));
      end else begin
        check("no_pulse", 32'({ack, err}), 32'd0);
      end
    end
  end

  // Called at a negedge; the request is accepted at the following rising edge.
  task automatic send(input logic [1:0] cmd, input int lat, input logic a, input logic e,
                      input logic [3:0] w, input logic lk);
    check("ready_at_send", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    sb.push_back('{cyc + lat, a, e, w, lk});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = 2'($urandom);
    @(negedge clk);
  endtask

  // Runs from cycle T+1 to T+S+1, offering requests that must be ignored while not ready.
  task automatic settle_check(input logic [3:0] w);
    for (int i = 0; i < S; i++) begin
      check("settle_ready", 32'(req_ready), 32'd0);
      check("settle_word",  32'(control_signal), 32'(w));
      req_valid = 1'b1;
      req_cmd   = 2'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("ready_back", 32'(req_ready), 32'd1);
    check("word_after", 32'(control_signal), 32'(w));
  endtask

  task automatic check_reset_vals();
    check("rst_word",   32'(control_signal), 32'(W_DIS));
    check("rst_ready",  32'(req_ready), 32'd1);
    check("rst_ack",    32'(ack), 32'd0);
    check("rst_err",    32'(err), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_err_count();
    if (!CNT_EN) return 8'h00;
    return (n_rej > 255) ? 8'hFF : 8'(n_rej);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rcmd;

    // Reset and release; the first edge after release accepts a request.
    idle(3);
    check_reset_vals();
    rst_n = 1'b1;
    idle(2);
    check_reset_vals();

    // 0010 -> 0001 with full settle window.
    send(2'b01, S + 1, 1'b1, 1'b0, W_EN, 1'b0);
    settle_check(W_EN);

    // Same-word and nop accepts back to back: immediate ack, ready stays high.
    send(2'b01, 1, 1'b1, 1'b0, W_EN, 1'b0);
    send(2'b01, 1, 1'b1, 1'b0, W_EN, 1'b0);
    send(2'b01, 1, 1'b1, 1'b0, W_EN, 1'b0);
    send(2'b00, 1, 1'b1, 1'b0, W_EN, 1'b0);
    check("ready_b2b", 32'(req_ready), 32'd1);
    idle(2);

    // 0001 -> 0010, then reset in cycle T+2: ack is lost and outputs clear at once.
    send(2'b10, S + 1, 1'b1, 1'b0, W_DIS, 1'b0);
    check("chg_word", 32'(control_signal), 32'(W_DIS));
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    idle(S + 3);
    check_reset_vals();

    send(2'b01, S + 1, 1'b1, 1'b0, W_EN, 1'b0);
    settle_check(W_EN);

    // Lock from 0001, then rejected requests and a nop.
    send(2'b11, S + 1, 1'b1, 1'b0, W_LOCK, 1'b1);
    settle_check(W_LOCK);
    check("locked_set", 32'(locked), 32'd1);
    send(2'b01, 1, 1'b0, 1'b1, W_LOCK, 1'b1); n_rej++;
    send(2'b10, 1, 1'b0, 1'b1, W_LOCK, 1'b1); n_rej++;
    send(2'b11, 1, 1'b0, 1'b1, W_LOCK, 1'b1); n_rej++;
    send(2'b00, 1, 1'b1, 1'b0, W_LOCK, 1'b1);
    idle(2);
    check("errcnt_3", 32'(err_count), 32'(exp_err_count()));
    check("lock_word", 32'(control_signal), 32'(W_LOCK));

    // Saturation: 300 more rejects, then a nop still acks.
    for (int i = 0; i < 300; i++) begin
      rcmd = 2'($urandom_range(1, 3));
      send(rcmd, 1, 1'b0, 1'b1, W_LOCK, 1'b1);
      n_rej++;
    end
    idle(2);
    check("errcnt_sat", 32'(err_count), 32'(exp_err_count()));
    send(2'b00, 1, 1'b1, 1'b0, W_LOCK, 1'b1);
    idle(2);
    check("errcnt_hold", 32'(err_count), 32'(exp_err_count()));

    // Lock directly from the reset word 0010.
    rst_n = 1'b0;
    sb.delete();
    n_rej = 0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b11, S + 1, 1'b1, 1'b0, W_LOCK, 1'b1);
    settle_check(W_LOCK);
    check("locked_from_dis", 32'(locked), 32'd1);

    idle(3);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
